mem_bist_ctrl: RTL and testbench

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

---
 rtl/mem_bist_pkg.sv | 22 ++
 rtl/mem_bist_cmp.sv | 57 +++++
 rtl/mem_bist_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST controller: FSM state encoding,
// default widths, error counter width and the address/seed test pattern.
package mem_bist_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int ERR_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Callers truncate the result to DATA_W, which leaves addr[DATA_W-1:0] ^ seed.
  function automatic logic [31:0] pattern(input logic [31:0] addr, input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-data checker: registers each issued read's expected word and address, compares
// against the returned word one cycle later, counts mismatches and keeps the first address.
// Define MEM_BIST_PARITY_CHK_EN to include the stored parity bit in the compare.
module mem_bist_cmp
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              kill,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_exp,
  input  logic [DATA_W:0]   data_out,
  output logic              err_now,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic              chk_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] exp_q;

`ifdef MEM_BIST_PARITY_CHK_EN
  assign err_now = chk_q && !kill && (data_out != {^exp_q, exp_q});
`else
  logic unused_parity;
  assign unused_parity = data_out[DATA_W];
  assign err_now = chk_q && !kill && (data_out[DATA_W-1:0] != exp_q);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_q          <= 1'b0;
      addr_q         <= '0;
      exp_q          <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      // An abort drops the in-flight read so result registers hold their values.
      chk_q  <= rd_en && !kill;
      addr_q <= rd_addr;
      exp_q  <= rd_exp;
      if (clr) begin
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (err_now) begin
        if (err_count == '0) first_err_addr <= addr_q;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-style memory BIST: write a pattern across [start_addr, end_addr], read it back,
// report pass/fail. Parity compare is enabled by defining MEM_BIST_PARITY_CHK_EN.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] seed,
  output logic              write,
  output logic              read,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W:0]   data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [2:0]        dbg_state
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] start_q, end_q, address_d;
  logic [DATA_W-1:0] seed_q, data_in_d, exp_data;
  logic              write_d, read_d, busy_d, done_d, pass_d;
  logic              accept, kill, err_now;

  assign dbg_state = state;
  assign exp_data  = DATA_W'(pattern(32'(address), 32'(seed_q)));

  always_comb begin
    state_d   = state;
    address_d = address;
    write_d   = 1'b0;
    read_d    = 1'b0;
    busy_d    = busy;
    done_d    = 1'b0;
    pass_d    = pass;
    accept    = 1'b0;
    kill      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (end_addr < start_addr) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            busy_d  = 1'b0;
          end else begin
            state_d   = S_WR;
            address_d = start_addr;
            write_d   = 1'b1;
            busy_d    = 1'b1;
            pass_d    = 1'b1;
          end
        end
      end
      // The address is compared against end before incrementing, so it never wraps.
      S_WR: begin
        if (address == end_q) begin
          state_d   = S_RD;
          address_d = start_q;
          read_d    = 1'b1;
        end else begin
          address_d = address + 1'b1;
          write_d   = 1'b1;
        end
      end
      S_RD: begin
        if (address == end_q) begin
          state_d = S_DRAIN;
        end else begin
          address_d = address + 1'b1;
          read_d    = 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_count == '0) && !err_now;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state == S_WR || state == S_RD || state == S_DRAIN)) begin
      kill      = 1'b1;
      state_d   = S_IDLE;
      address_d = address;
      write_d   = 1'b0;
      read_d    = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pass_d    = pass;
    end
    data_in_d = write_d ? DATA_W'(pattern(32'(address_d), 32'(accept ? seed : seed_q))) : data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      write   <= 1'b0;
      read    <= 1'b0;
      address <= '0;
      data_in <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      start_q <= '0;
      end_q   <= '0;
      seed_q  <= '0;
    end else begin
      state   <= state_d;
      write   <= write_d;
      read    <= read_d;
      address <= address_d;
      data_in <= data_in_d;
      busy    <= busy_d;
      done    <= done_d;
      pass    <= pass_d;
      if (accept) begin
        start_q <= start_addr;
        end_q   <= end_addr;
        seed_q  <= seed;
      end
    end
  end

  mem_bist_cmp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (accept),
    .kill           (kill),
    .rd_en          (read),
    .rd_addr        (address),
    .rd_exp         (exp_data),
    .data_out       (data_out),
    .err_now        (err_now),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: 9-bit parity memory model with write-time corruption,
// directed vector table, abort/reset sequences and randomized ranges.
module tb_mem_bist_ctrl;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic [DW-1:0] seed = '0;
  logic          write, read, busy, done, pass;
  logic [AW-1:0] address, first_err_addr;
  logic [DW-1:0] data_in;
  logic [DW:0]   data_out;
  logic [15:0]   err_count;
  logic [2:0]    dbg_state;

  logic [DW:0]   mem [0:65535];
  logic          flip_en = 1'b0;
  logic [AW-1:0] flip_a = '0;
  logic [DW:0]   flip_m = '0;
  int            checks = 0;
  int            errors = 0;

  typedef struct {
    logic [AW-1:0] sa;
    logic [AW-1:0] ea;
    logic [DW-1:0] seed;
    logic [AW-1:0] fa;
    logic [DW:0]   fm;
    bit            exp_pass;
    int            exp_err;
    logic [AW-1:0] exp_first;
    int            exp_cyc;
  } vec_t;

  mem_bist_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .start_addr     (start_addr),
    .end_addr       (end_addr),
    .seed           (seed),
    .write          (write),
    .read           (read),
    .address        (address),
    .data_in        (data_in),
    .data_out       (data_out),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  // Parity memory; a selected address is stored corrupted so the read phase sees it.
  always @(posedge clk) begin
    if (write) mem[address] <= {^data_in, data_in} ^ ((flip_en && address == flip_a) ? flip_m : '0);
    if (read) data_out <= mem[address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit corrupts(input logic [DW:0] m);
`ifdef MEM_BIST_PARITY_CHK_EN
    return m != '0;
`else
    return m[DW-1:0] != '0;
`endif
  endfunction

  // Reference: a test of N addresses takes N writes, N reads, one drain cycle, then done.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   e;
    r = v;
    e = 0;
    r.exp_first = '0;
    if (v.ea < v.sa) begin
      r.exp_pass = 1'b0;
      r.exp_err  = 0;
      r.exp_cyc  = 1;
      return r;
    end
    for (int a = int'(v.sa); a <= int'(v.ea); a++) begin
      if (AW'(a) == v.fa && corrupts(v.fm)) begin
        if (e == 0) r.exp_first = AW'(a);
        e++;
      end
    end
    r.exp_err  = e;
    r.exp_pass = (e == 0);
    r.exp_cyc  = 2 * (int'(v.ea) - int'(v.sa) + 1) + 2;
    return r;
  endfunction

  task automatic run_test(input string name, input vec_t v);
    logic [AW-1:0] wr_q[$];
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] exp_a;
    int n = 0, nwr = 0, nrd = 0, bad = 0, cyc = 0, len;
    len = (v.ea < v.sa) ? 0 : int'(v.ea) - int'(v.sa) + 1;
    for (int a = int'(v.sa); a <= int'(v.ea); a++) begin
      wr_q.push_back(AW'(a));
      rd_q.push_back(AW'(a));
    end
    flip_en = (v.fm != '0);
    flip_a  = v.fa;
    flip_m  = v.fm;
    start_addr = v.sa;
    end_addr   = v.ea;
    seed       = v.seed;
    start      = 1'b1;
    while (cyc == 0 && n < 2 * len + 10) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (write && read) bad++;
      if (write) begin
        nwr++;
        if (wr_q.size() == 0) bad++;
        else begin
          exp_a = wr_q.pop_front();
          if (address !== exp_a || data_in !== (exp_a[DW-1:0] ^ v.seed)) bad++;
        end
      end
      if (read) begin
        nrd++;
        if (wr_q.size() != 0 || rd_q.size() == 0) bad++;
        else begin
          exp_a = rd_q.pop_front();
          if (address !== exp_a) bad++;
        end
      end
      if (!done && !busy) bad++;
      if (done) begin
        cyc = n;
        if (busy) bad++;
      end
    end
    check({name, "_done_cycle"}, cyc, v.exp_cyc);
    check({name, "_pass"}, 32'(pass), 32'(v.exp_pass));
    check({name, "_err_count"}, 32'(err_count), v.exp_err);
    check({name, "_first_err_addr"}, 32'(first_err_addr), 32'(v.exp_first));
    check({name, "_writes"}, nwr, len);
    check({name, "_reads"}, nrd, len);
    check({name, "_protocol"}, bad, 0);
    @(posedge clk); #1;
    check({name, "_after_done"}, {28'd0, done, write, read, busy}, 32'd0);
    check({name, "_idle_state"}, 32'(dbg_state), 32'd0);
    flip_en = 1'b0;
  endtask

  task automatic abort_seq(input string name, input bit use_reset, input vec_t v);
    bit found = 1'b0;
    int done_cnt = 0;
    start_addr = 16'h0010;
    end_addr   = 16'h001F;
    seed       = 8'hA5;
    start      = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (read && address == 16'h0015) found = 1'b1;
    end
    check({name, "_reached_0015"}, 32'(found), 32'd1);
    if (use_reset) rst_n = 1'b0;
    else abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    rst_n = 1'b1;
    check({name, "_strobes"}, {30'd0, write, read}, 32'd0);
    check({name, "_busy_done"}, {30'd0, busy, done}, 32'd0);
    // Abort keeps the results from the start (pass=1, no errors); reset clears them.
    check({name, "_pass_held"}, 32'(pass), use_reset ? 32'd0 : 32'd1);
    check({name, "_err_held"}, 32'(err_count), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || write || read) done_cnt++;
    end
    check({name, "_no_done"}, done_cnt, 0);
    run_test({name, "_restart"}, v);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    int   len;

    tbl[0] = '{16'h0010, 16'h001F, 8'hA5, 16'h0000, 9'h000, 1'b1, 0, 16'h0000, 34};
    tbl[1] = '{16'h0010, 16'h001F, 8'hA5, 16'h0014, 9'h001, 1'b0, 1, 16'h0014, 34};
`ifdef MEM_BIST_PARITY_CHK_EN
    tbl[2] = '{16'h0010, 16'h001F, 8'hA5, 16'h0018, 9'h100, 1'b0, 1, 16'h0018, 34};
`else
    tbl[2] = '{16'h0010, 16'h001F, 8'hA5, 16'h0018, 9'h100, 1'b1, 0, 16'h0000, 34};
`endif
    tbl[3] = '{16'hFFFE, 16'hFFFF, 8'h3C, 16'h0000, 9'h000, 1'b1, 0, 16'h0000, 6};
    tbl[4] = '{16'h0020, 16'h001F, 8'h5A, 16'h0000, 9'h000, 1'b0, 0, 16'h0000, 1};
    tbl[5] = '{16'h0100, 16'h0100, 8'h00, 16'h0100, 9'h080, 1'b0, 1, 16'h0100, 4};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_strobes", {30'd0, write, read}, 32'd0);
    check("reset_status", {29'd0, busy, done, pass}, 32'd0);
    check("reset_err", {err_count, first_err_addr}, 32'd0);
    check("reset_addr_data", {8'd0, address, data_in}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_test($sformatf("vec%0d", i), tbl[i]);

    abort_seq("abort", 1'b0, tbl[0]);
    abort_seq("rst_mid", 1'b1, tbl[0]);

    for (int i = 0; i < 20; i++) begin
      len    = int'($urandom_range(1, 24));
      v.sa   = AW'($urandom_range(0, 65535));
      v.ea   = (int'(v.sa) + len - 1 > 65535) ? 16'hFFFF : AW'(int'(v.sa) + len - 1);
      if ($urandom_range(0, 9) == 0 && v.sa != '0) v.ea = v.sa - 1'b1;
      v.seed = DW'($urandom);
      v.fa   = AW'(int'(v.sa) + int'($urandom_range(0, len - 1)));
      v.fm   = '0;
      if ($urandom_range(0, 1) == 1) v.fm[$urandom_range(0, DW)] = 1'b1;
      v = model(v);
      run_test($sformatf("rand%0d", i), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
